bias_glb_reader: RTL and testbench

Read-side sequencer for the bias global buffer. On a start command it streams `count` consecutive 16-bit bias values beginning at `base_addr` out of the bias GLB. It drives the GLB's `re`/`raddr` pins, absorbs the GLB's one-cycle read latency, and presents the values on a valid/ready stream toward the PE-array bias injectors. A 2-entry output buffer lets it sustain one value per cycle under backpressure.

---
 rtl/bias_glb_pkg.sv | 15 +
 rtl/bias_rd_skid_buf.sv | 73 +++++++
 rtl/bias_glb_reader.sv | 117 +++++++++++
 tb/tb_bias_glb_reader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_glb_pkg.sv
// Shared types and constants for the bias GLB read sequencer.
package bias_glb_pkg;

  localparam int BIAS_DEPTH  = 384;
  localparam int BIAS_WIDTH  = 16;
  localparam int BIAS_RD_BUF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bias_rd_state_t;

endpackage

// File: rtl/bias_rd_skid_buf.sv
// Two-entry register FIFO between the GLB read port and the bias stream.
// Entry 0 is always the head; a synchronous flush empties it.
module bias_rd_skid_buf
  import bias_glb_pkg::*;
#(
  parameter int W = BIAS_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head_data,
  output logic         head_valid
);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   occ_q, occ_d;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    if (flush) begin
      occ_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) ent0_d = wdata;
          else               ent1_d = wdata;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          ent0_d = ent1_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          // pop needs a valid head, so occ is 1 or 2 here
          if (occ_q == 2'd1) begin
            ent0_d = wdata;
          end else begin
            ent0_d = ent1_q;
            ent1_d = wdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign occ        = occ_q;
  assign head_data  = ent0_q;
  assign head_valid = (occ_q != 2'd0);

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && occ_q == 2'(BIAS_RD_BUF)));

endmodule

// File: rtl/bias_glb_reader.sv
// Bias GLB read sequencer: streams `count` words from `base_addr` onto a
// valid/ready bus. Optional `abort` input enabled by BIAS_RD_ABORT_EN.
module bias_glb_reader
  import bias_glb_pkg::*;
#(
  parameter int DATA_WIDTH = BIAS_WIDTH,
  parameter int DEPTH      = BIAS_DEPTH,
  parameter int ADDR       = $clog2(DEPTH),
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  core_clk,
  input  logic                  core_rst_n,
`ifdef BIAS_RD_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  start,
  input  logic [ADDR-1:0]       base_addr,
  input  logic [CNT_W-1:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic                  glb_re,
  output logic [ADDR-1:0]       glb_raddr,
  input  logic [DATA_WIDTH-1:0] glb_rdata,
  output logic [DATA_WIDTH-1:0] bias_data,
  output logic                  bias_valid,
  input  logic                  bias_ready
);

  bias_rd_state_t  state_q, state_d;
  logic [ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR-1:0] raddr_q, raddr_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic            inflight_q, inflight_d;
  logic [1:0]      occ;
  logic [1:0]      occ_sum;
  logic            pop, issue, abort_w, abort_act;

`ifdef BIAS_RD_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // abort in DONE is moot: the pulse is already happening, so it just retires
  assign abort_act = abort_w && (state_q == READ || state_q == DRAIN);
  assign pop       = bias_valid && bias_ready;
  assign occ_sum   = occ + {1'b0, inflight_q};
  assign issue     = (state_q == READ) && (remaining_q != '0) && !abort_act &&
                     ((occ_sum < 2'(BIAS_RD_BUF)) || pop);

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    raddr_d     = raddr_q;
    remaining_d = remaining_q;
    inflight_d  = issue;
    if (issue) begin
      raddr_d     = rd_ptr_q;
      rd_ptr_d    = (rd_ptr_q == ADDR'(DEPTH - 1)) ? '0 : rd_ptr_q + ADDR'(1);
      remaining_d = remaining_q - CNT_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          rd_ptr_d    = base_addr;
          remaining_d = count;
          state_d     = (count == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (abort_act)                                state_d = DONE;
        else if (issue && remaining_q == CNT_W'(1))   state_d = DRAIN;
      end
      DRAIN: begin
        if (abort_act)                                state_d = DONE;
        else if (!inflight_q && occ == 2'd0)          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      raddr_q     <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      raddr_q     <= raddr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
    end
  end

  // the live pointer drives the pins while issuing; otherwise the last address holds
  assign glb_raddr = issue ? rd_ptr_q : raddr_q;
  assign glb_re    = issue;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  bias_rd_skid_buf #(.W(DATA_WIDTH)) u_buf (
    .clk        (core_clk),
    .rst_n      (core_rst_n),
    .flush      (abort_act),
    .push       (inflight_q && !abort_act),
    .wdata      (glb_rdata),
    .pop        (pop),
    .occ        (occ),
    .head_data  (bias_data),
    .head_valid (bias_valid)
  );

endmodule

// File: tb/tb_bias_glb_reader.sv
// Directed self-checking bench for bias_glb_reader with a one-cycle GLB model.
module tb_bias_glb_reader;

  logic        core_clk;
  logic        core_rst_n;
  logic        abort;
  logic        start;
  logic [8:0]  base_addr;
  logic [8:0]  count;
  logic        busy, done, glb_re, bias_valid, bias_ready;
  logic [8:0]  glb_raddr;
  logic [15:0] glb_rdata, bias_data;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t0     = 0;
  bit mon_en = 0;

  int          re_addr_log[$];
  int          re_cyc_log[$];
  logic [15:0] data_log[$];
  int          data_cyc_log[$];
  int          done_cyc_log[$];
  int          occ_err = 0, stall_err = 0, busy_cnt = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_data = '0;

  bias_glb_reader dut (
    .core_clk   (core_clk),
    .core_rst_n (core_rst_n),
`ifdef BIAS_RD_ABORT_EN
    .abort      (abort),
`endif
    .start      (start),
    .base_addr  (base_addr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .glb_re     (glb_re),
    .glb_raddr  (glb_raddr),
    .glb_rdata  (glb_rdata),
    .bias_data  (bias_data),
    .bias_valid (bias_valid),
    .bias_ready (bias_ready)
  );

  // clock / reset
  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;
  always @(posedge core_clk) cyc <= cyc + 1;

  function automatic logic [15:0] exp_val(input int a);
    return 16'(a) ^ 16'hA500;
  endfunction

  // GLB model: data appears the cycle after glb_re, garbage otherwise
  always @(posedge core_clk)
    glb_rdata <= glb_re ? exp_val(int'(glb_raddr)) : 16'hDEAD;

  // monitor: logs events relative to the command start
  always @(negedge core_clk) begin
    if (mon_en) begin
      if (glb_re) begin
        re_addr_log.push_back(int'(glb_raddr));
        re_cyc_log.push_back(cyc - t0);
      end
      if (bias_valid && bias_ready) begin
        data_log.push_back(bias_data);
        data_cyc_log.push_back(cyc - t0);
      end
      if (done) done_cyc_log.push_back(cyc - t0);
      if (busy) busy_cnt++;
      if (dut.occ > 2'd2) occ_err++;
      if (prev_stall && (!bias_valid || bias_data !== prev_data)) stall_err++;
      prev_stall = bias_valid && !bias_ready;
      prev_data  = bias_data;
    end else begin
      prev_stall = 0;
    end
  end

  int re_base, data_base, done_base, busy_base, occ_base, stall_base;
  bit finished;

  // driver: mode 0 ready=1, mode 1 ready pattern 1,0,0,1
  task automatic run_cmd(input int base, input int cnt, input int mode, input int restart_at);
    finished = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge core_clk); #1;
      if (k == 0) begin
        t0 = cyc;
        re_base = re_addr_log.size(); data_base = data_log.size();
        done_base = done_cyc_log.size(); busy_base = busy_cnt;
        occ_base = occ_err; stall_base = stall_err;
        mon_en = 1;
      end
      if (done_cyc_log.size() > done_base && k >= done_cyc_log[done_base] + 2) begin
        finished = 1;
        break;
      end
      start = 1'b0;
      if (k == 0) begin
        start = 1'b1; base_addr = 9'(base); count = 9'(cnt);
      end
      if (k == restart_at) begin
        start = 1'b1; base_addr = 9'd100; count = 9'd2;
      end
      bias_ready = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
    end
    start = 1'b0;
    bias_ready = 1'b1;
    mon_en = 0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL cmd_timeout: done not seen, base=%0d count=%0d", base, cnt);
    end
  endtask

  task automatic test_reset();
    core_rst_n = 1'b0; start = 0; abort = 0; base_addr = '0; count = '0; bias_ready = 1'b1;
    @(negedge core_clk);
    checks++;
    if ({busy, done, glb_re, bias_valid} !== 4'b0 || glb_raddr !== 9'd0 || bias_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b re=%b valid=%b raddr=%0d data=%h required all 0",
               busy, done, glb_re, bias_valid, glb_raddr, bias_data);
    end
    @(posedge core_clk); #1 core_rst_n = 1'b1;
    @(negedge core_clk);
    checks++;
    if ({busy, done, glb_re, bias_valid} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b re=%b valid=%b required 0", busy, done, glb_re, bias_valid);
    end
  endtask

  task automatic test_basic();
    run_cmd(0, 8, 0, -1);
    checks++;
    if (re_addr_log.size() - re_base != 8) begin
      errors++; $display("FAIL basic_re_count: got %0d required 8", re_addr_log.size() - re_base);
    end
    for (int i = 0; i < 8 && re_base + i < re_addr_log.size(); i++) begin
      checks++;
      if (re_addr_log[re_base+i] != i || re_cyc_log[re_base+i] != i + 1) begin
        errors++;
        $display("FAIL basic_re[%0d]: addr=%0d cyc=%0d required addr=%0d cyc=%0d",
                 i, re_addr_log[re_base+i], re_cyc_log[re_base+i], i, i + 1);
      end
    end
    checks++;
    if (data_log.size() - data_base != 8) begin
      errors++; $display("FAIL basic_data_count: got %0d required 8", data_log.size() - data_base);
    end
    for (int i = 0; i < 8 && data_base + i < data_log.size(); i++) begin
      checks++;
      if (data_log[data_base+i] !== exp_val(i) || data_cyc_log[data_base+i] != i + 3) begin
        errors++;
        $display("FAIL basic_data[%0d]: data=%h cyc=%0d required data=%h cyc=%0d",
                 i, data_log[data_base+i], data_cyc_log[data_base+i], exp_val(i), i + 3);
      end
    end
    checks++;
    if (done_cyc_log.size() - done_base != 1 || done_cyc_log[done_base] != 12) begin
      errors++;
      $display("FAIL basic_done: pulses=%0d first_cyc=%0d required 1 pulse at 12",
               done_cyc_log.size() - done_base, done_cyc_log[done_base]);
    end
  endtask

  task automatic test_wrap();
    run_cmd(380, 8, 0, -1);
    checks++;
    if (re_addr_log.size() - re_base != 8 || data_log.size() - data_base != 8) begin
      errors++;
      $display("FAIL wrap_count: re=%0d data=%0d required 8 and 8",
               re_addr_log.size() - re_base, data_log.size() - data_base);
    end
    for (int i = 0; i < 8 && data_base + i < data_log.size() && re_base + i < re_addr_log.size(); i++) begin
      checks++;
      if (re_addr_log[re_base+i] != (380 + i) % 384 || data_log[data_base+i] !== exp_val((380 + i) % 384)) begin
        errors++;
        $display("FAIL wrap[%0d]: addr=%0d data=%h required addr=%0d data=%h", i,
                 re_addr_log[re_base+i], data_log[data_base+i], (380 + i) % 384, exp_val((380 + i) % 384));
      end
    end
  endtask

  task automatic test_zero_count();
    run_cmd(5, 0, 0, -1);
    checks++;
    if (re_addr_log.size() != re_base || data_log.size() != data_base) begin
      errors++;
      $display("FAIL zero_activity: re=%0d data=%0d required 0 and 0",
               re_addr_log.size() - re_base, data_log.size() - data_base);
    end
    checks++;
    if (busy_cnt - busy_base != 1 || done_cyc_log[done_base] != 1) begin
      errors++;
      $display("FAIL zero_timing: busy_cycles=%0d done_cyc=%0d required 1 and 1",
               busy_cnt - busy_base, done_cyc_log[done_base]);
    end
  endtask

  task automatic test_backpressure();
    run_cmd(20, 6, 1, -1);
    checks++;
    if (occ_err != occ_base || stall_err != stall_base) begin
      errors++;
      $display("FAIL bp_stall: occ_errs=%0d stall_errs=%0d required 0 and 0",
               occ_err - occ_base, stall_err - stall_base);
    end
    checks++;
    if (data_log.size() - data_base != 6) begin
      errors++; $display("FAIL bp_count: got %0d required 6", data_log.size() - data_base);
    end
    for (int i = 0; i < 6 && data_base + i < data_log.size(); i++) begin
      checks++;
      if (data_log[data_base+i] !== exp_val(20 + i)) begin
        errors++;
        $display("FAIL bp_data[%0d]: got %h required %h", i, data_log[data_base+i], exp_val(20 + i));
      end
    end
  endtask

  task automatic test_restart_ignored();
    run_cmd(10, 4, 0, 3);
    checks++;
    if (re_addr_log.size() - re_base != 4 || data_log.size() - data_base != 4 ||
        done_cyc_log.size() - done_base != 1) begin
      errors++;
      $display("FAIL restart_counts: re=%0d data=%0d done=%0d required 4 4 1", re_addr_log.size() - re_base,
               data_log.size() - data_base, done_cyc_log.size() - done_base);
    end
    for (int i = 0; i < 4 && data_base + i < data_log.size(); i++) begin
      checks++;
      if (data_log[data_base+i] !== exp_val(10 + i)) begin
        errors++;
        $display("FAIL restart_data[%0d]: got %h required %h", i, data_log[data_base+i], exp_val(10 + i));
      end
    end
  endtask

  task automatic test_reset_mid_command();
    @(posedge core_clk); #1;
    start = 1'b1; base_addr = 9'd50; count = 9'd6; bias_ready = 1'b0;
    @(posedge core_clk); #1 start = 1'b0;
    repeat (5) @(posedge core_clk);
    #1;
    checks++;
    if (dut.occ !== 2'd2 || bias_valid !== 1'b1 || bias_data !== exp_val(50)) begin
      errors++;
      $display("FAIL mid_prefill: occ=%0d valid=%b data=%h required 2 1 %h", dut.occ, bias_valid, bias_data, exp_val(50));
    end
    core_rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, glb_re, bias_valid} !== 4'b0 || glb_raddr !== 9'd0 || bias_data !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: busy=%b done=%b re=%b valid=%b raddr=%0d data=%h required all 0",
               busy, done, glb_re, bias_valid, glb_raddr, bias_data);
    end
    bias_ready = 1'b1;
    repeat (2) @(posedge core_clk);
    #1 core_rst_n = 1'b1;
    run_cmd(200, 4, 0, -1);
    checks++;
    if (data_log.size() - data_base != 4) begin
      errors++; $display("FAIL post_reset_count: got %0d required 4", data_log.size() - data_base);
    end
    for (int i = 0; i < 4 && data_base + i < data_log.size(); i++) begin
      checks++;
      if (data_log[data_base+i] !== exp_val(200 + i)) begin
        errors++;
        $display("FAIL post_reset_data[%0d]: got %h required %h", i, data_log[data_base+i], exp_val(200 + i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_count();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid_command();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
